// File: rtl/sweeper_pkg.sv
// Shared FSM encoding and width helpers for the truth-table sweeper and its hold timer.
// Pure declarations; no latency, no backpressure.
package sweeper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic int nvec(input int n_in);
      return 1 << n_in;
   endfunction

   function automatic int idx_w(input int n_in);
      return n_in;
   endfunction

   // One extra bit so a sweep where every vector fails still fits.
   function automatic int cnt_w(input int n_in);
      return n_in + 1;
   endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Hold down-counter: load sets HOLD_CYCLES-1, expired flags zero, so DRIVE lasts HOLD_CYCLES cycles.
// Load takes effect at the next edge; no backpressure.
module sweep_hold_timer #(
   parameter int HOLD_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expired
);

   localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = TW'(HOLD_CYCLES - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every N_IN-bit vector onto a combinational DUT and checks dut_f against a latched truth table.
// done pulses 1+2^N_IN*(HOLD_CYCLES+1) edges after accepted start; start ignored while busy, abort cancels.
module truth_table_sweeper
   import sweeper_pkg::*;
#(
   parameter int N_IN        = 4,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [2**N_IN-1:0]   exp_tt,
   input  logic                 dut_f,
   output logic [N_IN-1:0]      stim,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_cnt,
   output logic                 fail_seen,
   output logic [N_IN-1:0]      first_fail
);

   localparam int NVEC = nvec(N_IN);
   localparam int IW   = idx_w(N_IN);
   localparam int CW   = cnt_w(N_IN);

   state_e            state_q, state_d;
   logic [NVEC-1:0]   tt_q, tt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     err_cnt_q, err_cnt_d;
   logic [IW-1:0]     first_fail_q, first_fail_d;
   logic              fail_seen_q, fail_seen_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              timer_load, timer_exp;

   sweep_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (timer_load),
      .expired (timer_exp)
   );

   always_comb begin
      state_d      = state_q;
      tt_d         = tt_q;
      idx_d        = idx_q;
      err_cnt_d    = err_cnt_q;
      first_fail_d = first_fail_q;
      fail_seen_d  = fail_seen_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      pass_d       = pass_q;
      timer_load   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            idx_d  = '0;
            busy_d = 1'b0;
            if (start && !abort) begin
               tt_d         = exp_tt;
               err_cnt_d    = '0;
               first_fail_d = '0;
               fail_seen_d  = 1'b0;
               pass_d       = 1'b0;
               busy_d       = 1'b1;
               timer_load   = 1'b1;
               state_d      = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (timer_exp) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (dut_f != tt_q[idx_q]) begin
               if (err_cnt_q != CW'(NVEC)) begin
                  err_cnt_d = err_cnt_q + CW'(1);
               end
               if (!fail_seen_q) begin
                  first_fail_d = idx_q;
                  fail_seen_d  = 1'b1;
               end
            end
            if (idx_q == IW'(NVEC - 1)) begin
               idx_d   = '0;
               state_d = ST_DONE;
            end else begin
               idx_d      = idx_q + IW'(1);
               timer_load = 1'b1;
               state_d    = ST_DRIVE;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            pass_d  = (err_cnt_q == '0);
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Cancel overrides everything above, including a sample taken this cycle.
      if (abort && state_q != ST_IDLE) begin
         state_d      = ST_IDLE;
         idx_d        = '0;
         busy_d       = 1'b0;
         done_d       = 1'b0;
         pass_d       = pass_q;
         err_cnt_d    = err_cnt_q;
         first_fail_d = first_fail_q;
         fail_seen_d  = fail_seen_q;
         timer_load   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tt_q         <= '0;
         idx_q        <= '0;
         err_cnt_q    <= '0;
         first_fail_q <= '0;
         fail_seen_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tt_q         <= tt_d;
         idx_q        <= idx_d;
         err_cnt_q    <= err_cnt_d;
         first_fail_q <= first_fail_d;
         fail_seen_q  <= fail_seen_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   assign stim       = idx_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_cnt    = err_cnt_q;
   assign fail_seen  = fail_seen_q;
   assign first_fail = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: reference lookup DUTs behind dut_f, result scoreboard per sweep.
module tb_truth_table_sweeper;

   typedef struct packed {
      logic [4:0] err;
      logic [3:0] ff;
      logic       fs;
      logic       pass;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, abort;
   logic [15:0] exp_tt;
   logic        dut_f;
   logic [3:0]  stim;
   logic        busy, done, pass, fail_seen;
   logic [4:0]  err_cnt;
   logic [3:0]  first_fail;

   logic        start2, abort2;
   logic [3:0]  exp_tt2;
   logic        dut_f2;
   logic [1:0]  stim2;
   logic        busy2, done2, pass2, fail_seen2;
   logic [2:0]  err_cnt2;
   logic [1:0]  first_fail2;

   logic [15:0] ref_tt  = 16'hB2E4;
   logic [3:0]  ref_tt2 = 4'b0110;
   logic        ref_tie0;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   assign dut_f  = ref_tie0 ? 1'b0 : ref_tt[stim];
   assign dut_f2 = ref_tt2[stim2];

   truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tt(exp_tt),
      .dut_f(dut_f), .stim(stim), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .fail_seen(fail_seen), .first_fail(first_fail)
   );

   truth_table_sweeper #(.N_IN(2), .HOLD_CYCLES(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .exp_tt(exp_tt2),
      .dut_f(dut_f2), .stim(stim2), .busy(busy2), .done(done2), .pass(pass2),
      .err_cnt(err_cnt2), .fail_seen(fail_seen2), .first_fail(first_fail2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic compare_result(input string tag, input bit got);
      exp_t e;
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      if (sb.size() == 0) begin
         check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_err_cnt"}, 32'(err_cnt), 32'(e.err));
         check({tag, "_first_fail"}, 32'(first_fail), 32'(e.ff));
         check({tag, "_fail_seen"}, 32'(fail_seen), 32'(e.fs));
         check({tag, "_pass"}, 32'(pass), 32'(e.pass));
      end
   endtask

   // Full 4-input sweep; optional mid-sweep restart attempt with a changed table.
   task automatic run_sweep(input string tag, input logic [15:0] tt, input bit tie0,
                            input bit poke, input exp_t e);
      int n;
      int walk_err;
      bit got;
      ref_tie0 = tie0;
      exp_tt   = tt;
      start    = 1'b1;
      sb.push_back(e);
      tick();
      start    = 1'b0;
      n        = 0;
      walk_err = 0;
      got      = 1'b0;
      check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
      while (n < 200 && !got) begin
         if (n <= 47 && stim !== 4'(n / 3)) walk_err++;
         if (n <= 47 && busy !== 1'b1) walk_err++;
         if (poke && n == 20) begin
            exp_tt = 16'h0000;
            start  = 1'b1;
         end
         if (poke && n == 21) start = 1'b0;
         tick();
         n++;
         if (done === 1'b1) got = 1'b1;
      end
      start = 1'b0;
      check({tag, "_latency"}, 32'(n), 32'd49);
      check({tag, "_stim_walk"}, 32'(walk_err), 32'd0);
      compare_result(tag, got);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      tick();
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      check({tag, "_pass_held"}, 32'(pass), 32'(e.pass));
      check({tag, "_stim_idle"}, 32'(stim), 32'd0);
   endtask

   initial begin
      int n;
      int done_cnt;
      bit got;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; exp_tt = 16'h0; ref_tie0 = 1'b0;
      start2 = 1'b0; abort2 = 1'b0; exp_tt2 = 4'h0;
      repeat (3) tick();
      check("rst_outputs", 32'({stim, busy, done, pass, err_cnt, fail_seen, first_fail}), 32'd0);
      rst_n = 1'b1;
      tick();

      // Matching table
      run_sweep("t1", 16'hB2E4, 1'b0, 1'b0, '{err: 5'd0, ff: 4'd0, fs: 1'b0, pass: 1'b1});
      // Bits 5 and 12 flipped
      run_sweep("t2", 16'hB2E4 ^ 16'h1020, 1'b0, 1'b0, '{err: 5'd2, ff: 4'd5, fs: 1'b1, pass: 1'b0});
      // Every vector fails; counter reaches 16 without wrapping
      run_sweep("t3", 16'hFFFF, 1'b1, 1'b0, '{err: 5'd16, ff: 4'd0, fs: 1'b1, pass: 1'b0});

      // Abort at stim=7 with one earlier mismatch at vector 2
      ref_tie0 = 1'b0;
      exp_tt   = 16'hB2E4 ^ 16'h0004;
      start    = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (n < 100 && stim !== 4'd7) begin
         tick();
         n++;
      end
      check("t4_reached_stim7", 32'(stim), 32'd7);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t4_stim_after_abort", 32'(stim), 32'd0);
      check("t4_busy_after_abort", 32'(busy), 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         if (done === 1'b1) done_cnt++;
         tick();
      end
      check("t4_no_done", 32'(done_cnt), 32'd0);
      check("t4_pass", 32'(pass), 32'd0);
      check("t4_partial_err", 32'(err_cnt), 32'd1);
      check("t4_partial_ff", 32'(first_fail), 32'd2);
      check("t4_partial_fs", 32'(fail_seen), 32'd1);

      // Start and abort together in IDLE: start dropped
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("t4_abort_wins_idle", 32'(busy), 32'd0);
      tick();
      check("t4_still_idle", 32'(busy), 32'd0);

      run_sweep("t4_restart", 16'hB2E4, 1'b0, 1'b0, '{err: 5'd0, ff: 4'd0, fs: 1'b0, pass: 1'b1});

      // Mid-sweep restart attempt and table change are ignored
      run_sweep("t5", 16'hB2E4, 1'b0, 1'b1, '{err: 5'd0, ff: 4'd0, fs: 1'b0, pass: 1'b1});

      // Reset asserted in a SAMPLE cycle while errors are accumulating
      ref_tie0 = 1'b1;
      exp_tt   = 16'hFFFF;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("t6_err_before_rst", 32'(err_cnt), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_outputs", 32'({stim, busy, done, pass, err_cnt, fail_seen, first_fail}), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      run_sweep("t6_clean", 16'hB2E4, 1'b0, 1'b0, '{err: 5'd0, ff: 4'd0, fs: 1'b0, pass: 1'b1});

      // Small instance: N_IN=2, HOLD_CYCLES=1
      exp_tt2 = 4'b0110;
      start2  = 1'b1;
      tick();
      start2 = 1'b0;
      n   = 0;
      got = 1'b0;
      while (n < 50 && !got) begin
         tick();
         n++;
         if (done2 === 1'b1) got = 1'b1;
      end
      check("t7_done_seen", 32'(got), 32'd1);
      check("t7_latency", 32'(n), 32'd9);
      check("t7_pass", 32'(pass2), 32'd1);
      check("t7_err_cnt", 32'(err_cnt2), 32'd0);
      check("t7_fail_seen", 32'(fail_seen2), 32'd0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
